// File: rtl/character_life_controller.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// character_life_controller
//
// Sequences the player character's life cycle (alive, dying, respawn,
// invulnerable, game over) from collision events. Keeps score, lives and the
// coin tally, and drives respawn / invincibility / game-over flags to the
// sprite and HUD logic. Every output comes straight from a register.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   evt_valid      collision event valid, one clk per event
//   Collision      contact sides {up,down,left,right} = [3:0]
//   Collision_Type object type: 302 monster, 102 coin, others ignored
//   frame_tick     one-clk pulse per video frame
//   restart        one-clk pulse, start a new game
//   State          0 ALIVE, 1 DYING, 2 RESPAWN, 3 INVULN, 4 GAME_OVER
//   Score          score, saturates at 2047
//   Life           remaining lives
//   coin_count     coins toward the next extra life
//   invincible     1 while State==INVULN
//   game_over      1 while State==GAME_OVER
//   respawn        1 for the single clk spent in RESPAWN
// -----------------------------------------------------------------------------
module character_life_controller #(
  parameter int unsigned INIT_LIFE      = 3,
  parameter int unsigned MAX_LIFE       = 99,
  parameter int unsigned COIN_PTS       = 1,
  parameter int unsigned STOMP_PTS      = 3,
  parameter int unsigned COINS_PER_LIFE = 100,
  parameter int unsigned DEATH_TICKS    = 50,
  parameter int unsigned INVULN_TICKS   = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_valid,
  input  logic [3:0]  Collision,
  input  logic [10:0] Collision_Type,
  input  logic        frame_tick,
  input  logic        restart,
  output logic [10:0] State,
  output logic [10:0] Score,
  output logic [10:0] Life,
  output logic [6:0]  coin_count,
  output logic        invincible,
  output logic        game_over,
  output logic        respawn
);

  localparam int unsigned TICKS_MAX = (DEATH_TICKS > INVULN_TICKS) ? DEATH_TICKS : INVULN_TICKS;
  localparam int unsigned TIMER_W   = $clog2(TICKS_MAX + 1);

  localparam logic [10:0] TYPE_MONSTER = 11'd302;
  localparam logic [10:0] TYPE_COIN    = 11'd102;

  typedef enum logic [2:0] {
    ALIVE     = 3'd0,
    DYING     = 3'd1,
    RESPAWN   = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [10:0]          score_q, score_d;
  logic [10:0]          life_q,  life_d;
  logic [6:0]           coin_q,  coin_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 inv_q, go_q, resp_q;

  // Event decode. Only the "down" contact side distinguishes a stomp from a hit.
  logic is_monster, is_stomp, is_hit, is_coin;
  assign is_monster = evt_valid && (Collision_Type == TYPE_MONSTER);
  assign is_stomp   = is_monster &&  Collision[2];
  assign is_hit     = is_monster && !Collision[2];
  assign is_coin    = evt_valid && (Collision_Type == TYPE_COIN);

  // The other contact sides carry no meaning for this block.
  logic unused_collision;
  assign unused_collision = ^{Collision[3], Collision[1:0]};

  // Score additions use a 12-bit sum so the carry out selects the clamp.
  logic [11:0] stomp_sum, coin_sum;
  logic [10:0] score_stomp, score_coin;
  assign stomp_sum   = {1'b0, score_q} + 12'(STOMP_PTS);
  assign coin_sum    = {1'b0, score_q} + 12'(COIN_PTS);
  assign score_stomp = stomp_sum[11] ? 11'h7FF : stomp_sum[10:0];
  assign score_coin  = coin_sum[11]  ? 11'h7FF : coin_sum[10:0];

  // Coin tally: wrapping the tally awards a life, saturating at MAX_LIFE.
  logic        coin_wrap;
  logic [6:0]  coin_inc;
  logic [10:0] life_bonus;
  assign coin_wrap  = (coin_q == 7'(COINS_PER_LIFE - 1));
  assign coin_inc   = coin_wrap ? 7'd0 : coin_q + 7'd1;
  assign life_bonus = (life_q >= 11'(MAX_LIFE)) ? 11'(MAX_LIFE) : life_q + 11'd1;

  // A timed state expires on the tick that brings the timer to zero.
  logic timer_done;
  assign timer_done = (timer_q == '0) || (frame_tick && (timer_q == TIMER_W'(1)));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    score_d = score_q;
    life_d  = life_q;
    coin_d  = coin_q;
    timer_d = timer_q;

    if (restart) begin
      score_d = '0;
      life_d  = 11'(INIT_LIFE);
      coin_d  = '0;
      state_d = RESPAWN;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (is_hit) begin
            // The timer reload wins over a same-cycle tick.
            state_d = DYING;
            life_d  = (life_q == '0) ? '0 : life_q - 11'd1;
            timer_d = TIMER_W'(DEATH_TICKS);
          end else if (is_stomp) begin
            score_d = score_stomp;
          end else if (is_coin) begin
            score_d = score_coin;
            coin_d  = coin_inc;
            if (coin_wrap) life_d = life_bonus;
          end
        end
        DYING: begin
          if (frame_tick && timer_q != '0) timer_d = timer_q - TIMER_W'(1);
          if (timer_done) state_d = (life_q == '0) ? GAME_OVER : RESPAWN;
        end
        RESPAWN: begin
          state_d = INVULN;
          timer_d = TIMER_W'(INVULN_TICKS);
        end
        INVULN: begin
          // Scoring and expiry are independent, so both may land on one edge.
          if (is_stomp) begin
            score_d = score_stomp;
          end else if (is_coin) begin
            score_d = score_coin;
            coin_d  = coin_inc;
            if (coin_wrap) life_d = life_bonus;
          end
          if (frame_tick && timer_q != '0) timer_d = timer_q - TIMER_W'(1);
          if (timer_done) state_d = ALIVE;
        end
        GAME_OVER: ;
        default: state_d = ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      score_q <= '0;
      life_q  <= 11'(INIT_LIFE);
      coin_q  <= '0;
      timer_q <= '0;
      inv_q   <= 1'b0;
      go_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      score_q <= score_d;
      life_q  <= life_d;
      coin_q  <= coin_d;
      timer_q <= timer_d;
      // Flags are decoded from the next state so they change with State.
      inv_q   <= (state_d == INVULN);
      go_q    <= (state_d == GAME_OVER);
      resp_q  <= (state_d == RESPAWN);
    end
  end

  assign State      = {8'd0, state_q};
  assign Score      = score_q;
  assign Life       = life_q;
  assign coin_count = coin_q;
  assign invincible = inv_q;
  assign game_over  = go_q;
  assign respawn    = resp_q;

endmodule

// File: tb/tb_character_life_controller.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_character_life_controller
//
// Directed bench for character_life_controller. Expected output snapshots are
// queued when the stimulus is driven and popped and compared after the DUT
// has updated. A second instance with MAX_LIFE=4 shares the stimulus and is
// used for the life-saturation case.
// -----------------------------------------------------------------------------
module tb_character_life_controller;

  localparam logic [10:0] T_MON   = 11'd302;
  localparam logic [10:0] T_COIN  = 11'd102;
  localparam logic [10:0] T_OTHER = 11'd7;
  localparam logic [3:0]  C_DOWN  = 4'b0100;
  localparam logic [3:0]  C_LEFT  = 4'b0010;
  localparam logic [3:0]  C_RIGHT = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid = 1'b0;
  logic [3:0]  collision = '0;
  logic [10:0] collision_type = '0;
  logic        frame_tick = 1'b0;
  logic        restart = 1'b0;

  logic [10:0] state, score, life;
  logic [6:0]  coin_count;
  logic        invincible, game_over, respawn;

  logic [10:0] s_state, s_score, s_life;
  logic [6:0]  s_coin_count;
  logic        s_invincible, s_game_over, s_respawn;

  character_life_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .evt_valid      (evt_valid),
    .Collision      (collision),
    .Collision_Type (collision_type),
    .frame_tick     (frame_tick),
    .restart        (restart),
    .State          (state),
    .Score          (score),
    .Life           (life),
    .coin_count     (coin_count),
    .invincible     (invincible),
    .game_over      (game_over),
    .respawn        (respawn)
  );

  character_life_controller #(.MAX_LIFE(4)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .evt_valid      (evt_valid),
    .Collision      (collision),
    .Collision_Type (collision_type),
    .frame_tick     (frame_tick),
    .restart        (restart),
    .State          (s_state),
    .Score          (s_score),
    .Life           (s_life),
    .coin_count     (s_coin_count),
    .invincible     (s_invincible),
    .game_over      (s_game_over),
    .respawn        (s_respawn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] st;
    logic [10:0] sc;
    logic [10:0] lf;
    logic [6:0]  cn;
    logic        inv;
    logic        go;
    logic        rsp;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Queue the snapshot the DUT must show once the next stimulus has landed.
  task automatic expect_out(input string tag, input int st, input int sc, input int lf,
                            input int cn, input bit inv, input bit go, input bit rsp);
    snap_t e;
    e.st  = 11'(st);
    e.sc  = 11'(sc);
    e.lf  = 11'(lf);
    e.cn  = 7'(cn);
    e.inv = inv;
    e.go  = go;
    e.rsp = rsp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    snap_t obs, e;
    string tag;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = '{st: state, sc: score, lf: life, cn: coin_count,
            inv: invincible, go: game_over, rsp: respawn};
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: got st=%0d score=%0d life=%0d coin=%0d inv=%0b go=%0b rsp=%0b, want st=%0d score=%0d life=%0d coin=%0d inv=%0b go=%0b rsp=%0b",
             tag, obs.st, obs.sc, obs.lf, obs.cn, obs.inv, obs.go, obs.rsp,
             e.st, e.sc, e.lf, e.cn, e.inv, e.go, e.rsp);
    end
  endtask

  // Drive one clock of inputs from a negedge; return at the next negedge.
  task automatic apply(input logic ev, input logic [3:0] col, input logic [10:0] typ,
                       input logic tick, input logic rs);
    evt_valid      = ev;
    collision      = col;
    collision_type = typ;
    frame_tick     = tick;
    restart        = rs;
    @(negedge clk);
    evt_valid      = 1'b0;
    collision      = '0;
    collision_type = '0;
    frame_tick     = 1'b0;
    restart        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 4'd0, 11'd0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) apply(1'b0, 4'd0, 11'd0, 1'b1, 1'b0);
  endtask

  task automatic stomp();
    apply(1'b1, C_DOWN, T_MON, 1'b0, 1'b0);
  endtask

  task automatic hit(input logic [3:0] col);
    apply(1'b1, col, T_MON, 1'b0, 1'b0);
  endtask

  task automatic coin();
    apply(1'b1, 4'd0, T_COIN, 1'b0, 1'b0);
  endtask

  // Hit, die, respawn and sit out invulnerability, ending back in ALIVE.
  task automatic full_death();
    hit(C_LEFT);
    ticks(50);
    idle(1);
    ticks(120);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    expect_out("reset_state", 0, 0, 3, 0, 0, 0, 0);
    check();

    expect_out("other_type_noop", 0, 0, 3, 0, 0, 0, 0);
    apply(1'b1, C_DOWN, T_OTHER, 1'b0, 1'b0);
    check();

    // Coin rollover.
    expect_out("coins_100", 0, 100, 4, 0, 0, 0, 0);
    repeat (100) coin();
    check();

    expect_out("coins_199", 0, 199, 4, 99, 0, 0, 0);
    repeat (99) coin();
    check();

    expect_out("coins_200", 0, 200, 5, 0, 0, 0, 0);
    coin();
    check();

    n_tests++;
    assert (s_life === 11'd4) else begin
      n_fail++;
      $error("FAIL life_saturation: got life=%0d, want 4", s_life);
    end

    // Stomp versus hit.
    expect_out("stomp", 0, 203, 5, 0, 0, 0, 0);
    stomp();
    check();

    expect_out("side_hit", 1, 203, 4, 0, 0, 0, 0);
    hit(C_LEFT);
    check();

    expect_out("dying_ignores_coin", 1, 203, 4, 0, 0, 0, 0);
    coin();
    check();

    expect_out("dying_ignores_stomp", 1, 203, 4, 0, 0, 0, 0);
    stomp();
    check();

    // Death sequence.
    expect_out("dying_49_ticks", 1, 203, 4, 0, 0, 0, 0);
    ticks(49);
    check();

    expect_out("respawn_pulse", 2, 203, 4, 0, 0, 0, 1);
    ticks(1);
    check();

    expect_out("invuln_entry", 3, 203, 4, 0, 1, 0, 0);
    idle(1);
    check();

    expect_out("invuln_hit_ignored", 3, 203, 4, 0, 1, 0, 0);
    hit(C_RIGHT);
    check();

    expect_out("invuln_stomp", 3, 206, 4, 0, 1, 0, 0);
    stomp();
    check();

    expect_out("invuln_119_ticks", 3, 206, 4, 0, 1, 0, 0);
    ticks(119);
    check();

    expect_out("invuln_exit_with_coin", 0, 207, 4, 1, 0, 0, 0);
    apply(1'b1, 4'd0, T_COIN, 1'b1, 1'b0);
    check();

    // A hit with a tick reloads the timer; that tick does not count.
    expect_out("hit_with_tick", 1, 207, 3, 1, 0, 0, 0);
    apply(1'b1, C_LEFT, T_MON, 1'b1, 1'b0);
    check();

    expect_out("hit_tick_then_49", 1, 207, 3, 1, 0, 0, 0);
    ticks(49);
    check();

    // Asynchronous reset in the middle of DYING, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 3, 0, 0, 0, 0);
    check();
    @(negedge clk);
    rst_n = 1'b1;

    expect_out("after_reset", 0, 0, 3, 0, 0, 0, 0);
    idle(1);
    check();

    // Game over after three completed deaths.
    expect_out("death_1", 0, 0, 2, 0, 0, 0, 0);
    full_death();
    check();

    expect_out("death_2", 0, 0, 1, 0, 0, 0, 0);
    full_death();
    check();

    expect_out("game_over", 4, 0, 0, 0, 0, 1, 0);
    hit(C_LEFT);
    ticks(50);
    check();

    expect_out("go_ignores_stomp_tick", 4, 0, 0, 0, 0, 1, 0);
    apply(1'b1, C_DOWN, T_MON, 1'b1, 1'b0);
    check();

    expect_out("go_ignores_coin_tick", 4, 0, 0, 0, 0, 1, 0);
    apply(1'b1, 4'd0, T_COIN, 1'b1, 1'b0);
    check();

    expect_out("restart_over_event", 2, 0, 3, 0, 0, 0, 1);
    apply(1'b1, C_DOWN, T_MON, 1'b0, 1'b1);
    check();

    expect_out("restart_invuln", 3, 0, 3, 0, 1, 0, 0);
    idle(1);
    check();

    // Score saturation from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    expect_out("stomps_682", 0, 2046, 3, 0, 0, 0, 0);
    repeat (682) stomp();
    check();

    expect_out("stomp_clamps", 0, 2047, 3, 0, 0, 0, 0);
    stomp();
    check();

    expect_out("coin_at_max", 0, 2047, 3, 1, 0, 0, 0);
    coin();
    check();

    expect_out("stomp_at_max", 0, 2047, 3, 1, 0, 0, 0);
    stomp();
    check();

    expect_out("restart_from_alive", 2, 0, 3, 0, 0, 0, 1);
    apply(1'b0, 4'd0, 11'd0, 1'b0, 1'b1);
    check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
